// File: rtl/parking_fee_unit.sv
// parking_fee_unit: per-slot occupancy and billing stage.
// Records entry hours, bills exits across midnight, tracks revenue.
module parking_fee_unit #(
    parameter int N_SLOTS = 8,
    parameter int SLOT_W  = 4,
    parameter int RATE    = 3,
    parameter int FEE_W   = 8,
    parameter int REV_W   = 16
) (
    input  logic               CLK,
    input  logic               Start_n,
    input  logic [4:0]         hour,
    input  logic               car_in,
    input  logic               car_out,
    input  logic [SLOT_W-1:0]  slot_id,
    output logic [N_SLOTS-1:0] occupied,
    output logic [4:0]         free_count,
    output logic               full,
    output logic [FEE_W-1:0]   fee,
    output logic               fee_valid,
    output logic               err,
    output logic [REV_W-1:0]   revenue
);

    localparam int          IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [31:0] NS_U    = N_SLOTS;
    localparam logic [31:0] RATE_U  = RATE;
    localparam logic [31:0] FEE_MAX = 32'((64'd1 << FEE_W) - 64'd1);
    localparam logic [32:0] REV_MAX = 33'((64'd1 << REV_W) - 64'd1);

    logic [4:0]       entry_hr [N_SLOTS];
    logic [IDX_W-1:0] idx;
    logic             slot_ok;
    logic             hour_ok;
    logic             busy;
    logic             bad;
    logic             acc_in;
    logic             acc_out;
    logic             rej;
    logic [5:0]       span;
    logic [5:0]       dur;
    logic [4:0]       billed;
    logic [31:0]      raw_fee;
    logic [FEE_W-1:0] fee_n;
    logic [32:0]      rev_sum;
    logic [REV_W-1:0] rev_n;

    assign idx = slot_id[IDX_W-1:0];

    // Validate the request and work out the fee an exit would produce.
    always_comb begin
        slot_ok = 32'(slot_id) < NS_U;
        hour_ok = hour <= 5'd23;
        busy    = occupied[idx];
        bad     = (car_in & car_out) | ~slot_ok | ~hour_ok
                | (car_in & busy) | (car_out & ~busy);
        acc_in  = car_in & ~bad;
        acc_out = car_out & ~bad;
        rej     = (car_in | car_out) & bad;
        // +24 keeps the subtraction positive across midnight
        span    = {1'b0, hour} + 6'd24 - {1'b0, entry_hr[idx]};
        dur     = (span >= 6'd24) ? span - 6'd24 : span;
        billed  = (dur == 6'd0) ? 5'd1 : dur[4:0];
        raw_fee = 32'(billed) * RATE_U;
        fee_n   = (raw_fee > FEE_MAX) ? FEE_MAX[FEE_W-1:0]
                                      : raw_fee[FEE_W-1:0];
        rev_sum = 33'(revenue) + 33'(fee_n);
        rev_n   = (rev_sum > REV_MAX) ? REV_MAX[REV_W-1:0]
                                      : rev_sum[REV_W-1:0];
    end

    // Commit accepted entries/exits and register all outputs.
    always_ff @(posedge CLK or negedge Start_n) begin
        if (!Start_n) begin
            occupied   <= '0;
            free_count <= 5'(N_SLOTS);
            full       <= 1'b0;
            fee        <= '0;
            fee_valid  <= 1'b0;
            err        <= 1'b0;
            revenue    <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                entry_hr[i] <= 5'd0;
            end
        end else begin
            fee_valid <= acc_out;
            err       <= rej;
            if (acc_in) begin
                occupied[idx] <= 1'b1;
                entry_hr[idx] <= hour;
                free_count    <= free_count - 5'd1;
                full          <= (free_count == 5'd1);
            end
            if (acc_out) begin
                occupied[idx] <= 1'b0;
                fee           <= fee_n;
                revenue       <= rev_n;
                free_count    <= free_count + 5'd1;
                full          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parking_fee_unit.sv
// tb_parking_fee_unit: directed plus random checks of parking_fee_unit.
// A default instance and a RATE=20 / REV_W=8 saturation instance.
module tb_parking_fee_unit;

    logic        CLK = 1'b0;
    logic        Start_n = 1'b0;
    logic [4:0]  hour = '0;
    logic        car_in = 1'b0;
    logic        car_out = 1'b0;
    logic [3:0]  slot_id = '0;
    logic [7:0]  occupied;
    logic [4:0]  free_count;
    logic        full;
    logic [7:0]  fee;
    logic        fee_valid;
    logic        err;
    logic [15:0] revenue;

    logic [4:0]  s_hour = '0;
    logic        s_car_in = 1'b0;
    logic        s_car_out = 1'b0;
    logic [3:0]  s_slot_id = '0;
    logic [7:0]  s_occupied;
    logic [4:0]  s_free_count;
    logic        s_full;
    logic [7:0]  s_fee;
    logic        s_fee_valid;
    logic        s_err;
    logic [7:0]  s_revenue;

    int n_vec = 0;
    int n_mis = 0;

    parking_fee_unit u_dut (
        .CLK(CLK), .Start_n(Start_n), .hour(hour),
        .car_in(car_in), .car_out(car_out), .slot_id(slot_id),
        .occupied(occupied), .free_count(free_count), .full(full),
        .fee(fee), .fee_valid(fee_valid), .err(err), .revenue(revenue)
    );

    parking_fee_unit #(.RATE(20), .REV_W(8)) u_sat (
        .CLK(CLK), .Start_n(Start_n), .hour(s_hour),
        .car_in(s_car_in), .car_out(s_car_out), .slot_id(s_slot_id),
        .occupied(s_occupied), .free_count(s_free_count), .full(s_full),
        .fee(s_fee), .fee_valid(s_fee_valid), .err(s_err),
        .revenue(s_revenue)
    );

    always #5 CLK = ~CLK;

    // Reference model: one record per instance, plain integer arithmetic.
    bit m_occ [2][8];
    int m_ent [2][8];
    int m_fee [2];
    int m_rev [2];
    int m_fv  [2];
    int m_err [2];

    function automatic int rate_of(int k);
        return (k == 0) ? 3 : 20;
    endfunction

    function automatic int revmax_of(int k);
        return (k == 0) ? 65535 : 255;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_occ[k][i] = 0;
                m_ent[k][i] = 0;
            end
            m_fee[k] = 0;
            m_rev[k] = 0;
            m_fv[k]  = 0;
            m_err[k] = 0;
        end
    endfunction

    function automatic void m_step(int k, bit ci, bit co, int s, int h);
        int d;
        int f;
        m_fv[k]  = 0;
        m_err[k] = 0;
        if (!ci && !co) return;
        if ((ci && co) || s >= 8 || h > 23) begin
            m_err[k] = 1;
            return;
        end
        if ((ci && m_occ[k][s]) || (co && !m_occ[k][s])) begin
            m_err[k] = 1;
            return;
        end
        if (ci) begin
            m_occ[k][s] = 1;
            m_ent[k][s] = h;
        end else begin
            d = (((h - m_ent[k][s]) % 24) + 24) % 24;
            f = ((d == 0) ? 1 : d) * rate_of(k);
            if (f > 255) f = 255;
            m_fee[k] = f;
            m_rev[k] = m_rev[k] + f;
            if (m_rev[k] > revmax_of(k)) m_rev[k] = revmax_of(k);
            m_occ[k][s] = 0;
            m_fv[k] = 1;
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(int k, string tag);
        logic [31:0] eo;
        int          nf;
        eo = '0;
        nf = 8;
        for (int i = 0; i < 8; i++) begin
            eo[i] = m_occ[k][i];
            if (m_occ[k][i]) nf--;
        end
        if (k == 0) begin
            check({tag, ".occ"},  32'(occupied),   eo);
            check({tag, ".free"}, 32'(free_count), 32'(nf));
            check({tag, ".full"}, 32'(full),       32'(nf == 0));
            check({tag, ".fee"},  32'(fee),        32'(m_fee[k]));
            check({tag, ".fv"},   32'(fee_valid),  32'(m_fv[k]));
            check({tag, ".err"},  32'(err),        32'(m_err[k]));
            check({tag, ".rev"},  32'(revenue),    32'(m_rev[k]));
        end else begin
            check({tag, ".occ"},  32'(s_occupied),   eo);
            check({tag, ".free"}, 32'(s_free_count), 32'(nf));
            check({tag, ".full"}, 32'(s_full),       32'(nf == 0));
            check({tag, ".fee"},  32'(s_fee),        32'(m_fee[k]));
            check({tag, ".fv"},   32'(s_fee_valid),  32'(m_fv[k]));
            check({tag, ".err"},  32'(s_err),        32'(m_err[k]));
            check({tag, ".rev"},  32'(s_revenue),    32'(m_rev[k]));
        end
    endtask

    task automatic step(int k, bit ci, bit co, int s, int h, string tag);
        @(negedge CLK);
        if (k == 0) begin
            car_in = ci; car_out = co;
            slot_id = 4'(s); hour = 5'(h);
        end else begin
            s_car_in = ci; s_car_out = co;
            s_slot_id = 4'(s); s_hour = 5'(h);
        end
        @(posedge CLK);
        #1;
        car_in = 1'b0; car_out = 1'b0;
        s_car_in = 1'b0; s_car_out = 1'b0;
        m_step(k, ci, co, s, h);
        check_all(k, tag);
    endtask

    task automatic reset_between(string tag);
        @(negedge CLK);
        #2 Start_n = 1'b0;
        #1;
        m_reset();
        check_all(0, tag);
        check_all(1, {tag, "_sat"});
        @(negedge CLK);
        Start_n = 1'b1;
    endtask

    initial begin
        int r;
        int s;
        int h;
        m_reset();
        Start_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all(0, "rst");
        check_all(1, "rst_sat");
        @(negedge CLK);
        Start_n = 1'b1;
        step(0, 0, 0, 0, 0, "idle");

        step(0, 1, 0, 2, 5, "basic_in");
        step(0, 0, 1, 2, 9, "basic_out");
        check("basic_fee", 32'(fee), 32'd12);
        check("basic_rev", 32'(revenue), 32'd12);

        reset_between("midrst");
        step(0, 1, 0, 0, 22, "wrap_in");
        step(0, 1, 0, 1, 7, "min_in");
        step(0, 0, 1, 0, 3, "wrap_out");
        check("wrap_fee", 32'(fee), 32'd15);
        step(0, 0, 1, 1, 7, "min_out");
        check("min_fee", 32'(fee), 32'd3);
        check("wm_rev", 32'(revenue), 32'd18);

        step(0, 1, 0, 3, 1, "e_setup");
        step(0, 1, 0, 3, 2, "e_in_occ");
        step(0, 0, 1, 4, 2, "e_out_empty");
        step(0, 1, 0, 9, 2, "e_slot9");
        step(0, 1, 1, 5, 2, "e_both");
        step(0, 1, 0, 5, 25, "e_hour25");
        check("e_err", 32'(err), 32'd1);

        reset_between("fillrst");
        for (int i = 0; i < 8; i++) step(0, 1, 0, i, 10, "fill");
        check("fill_full", 32'(full), 32'd1);
        step(0, 1, 0, 0, 11, "ninth_in");
        step(0, 0, 1, 4, 12, "one_out");
        check("one_out_free", 32'(free_count), 32'd1);
        step(0, 1, 0, 4, 13, "re_in");

        step(1, 1, 0, 0, 0, "sat_in");
        step(1, 0, 1, 0, 23, "sat_out");
        check("sat_fee", 32'(s_fee), 32'd255);
        step(1, 1, 0, 1, 1, "sat_in2");
        step(1, 0, 1, 1, 5, "sat_out2");
        step(1, 1, 0, 1, 6, "sat_in3");
        step(1, 0, 1, 1, 9, "sat_out3");
        check("sat_rev", 32'(s_revenue), 32'd255);

        reset_between("rndrst");
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) s = 8 + int'($urandom_range(0, 7));
            else s = int'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) h = 24 + int'($urandom_range(0, 7));
            else h = int'($urandom_range(0, 23));
            step(0, (r < 4) || (r == 8), (r >= 4 && r < 8) || (r == 8),
                 s, h, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/parking_fee_unit.md
# parking_fee_unit

Per-slot occupancy and billing stage that sits directly downstream of the hour counter. It consumes the 0–23 `hour` value and records the entry hour of each car per slot. On exit it computes the parked duration across midnight wrap-around and issues a registered, one-cycle fee result. It also maintains occupancy, free-slot count and a saturating revenue total for the display/controller logic.

## Interface
- `N_SLOTS`, 8: number of parking slots (2..16).
- `SLOT_W`, 4: width of `slot_id`; must satisfy 2^SLOT_W ≥ N_SLOTS.
- `RATE`, 3: fee units per billed hour.
- `FEE_W`, 8: width of `fee`.
- `REV_W`, 16: width of `revenue`.

Ports:
- `CLK` input 1: single clock; all state changes on the rising edge.
- `Start_n` input 1: asynchronous, active-low reset.
- `hour` input 5: current hour from the time counter; legal range 0..23.
- `car_in` input 1: one-cycle entry request for `slot_id`.
- `car_out` input 1: one-cycle exit request for `slot_id`.
- `slot_id` input SLOT_W: target slot of the request.
- `occupied` output N_SLOTS: bit i = slot i holds a car.
- `free_count` output 5: number of unoccupied slots.
- `full` output 1: high when `free_count == 0`.
- `fee` output FEE_W: fee of the most recent accepted exit; held until the next accepted exit.
- `fee_valid` output 1: one-cycle pulse marking a new `fee`.
- `err` output 1: one-cycle pulse marking a rejected request.
- `revenue` output REV_W: saturating sum of all issued fees.

## Operation
- Storage: per slot, one occupied flag and a 5-bit entry hour.
- A request is rejected, with `err` pulsed and no other state change, when:
  - `car_in` and `car_out` are both high in the same cycle;
  - `slot_id ≥ N_SLOTS`;
  - `hour > 23`;
  - `car_in` targets an occupied slot;
  - `car_out` targets an empty slot.
- Accepted entry:
  - set `occupied[slot_id]`;
  - store `hour` as the slot's entry hour;
  - decrement `free_count`.
- Accepted exit:
  - duration d = (hour − entry + 24) mod 24, computed at 6-bit width before the mod;
  - billed hours b = d, except b = 1 when d = 0 (minimum charge);
  - fee = b × RATE, saturating to 2^FEE_W − 1;
  - clear `occupied[slot_id]`; increment `free_count`;
  - `revenue` += fee, saturating at 2^REV_W − 1 (never wraps).
- Stays longer than 24 h cannot be detected. The duration is taken mod 24 by definition.
- `car_in` is ignored when `full`. This is inherent, because every slot is occupied, so the request fails the occupied-slot check and `err` pulses.
- No request (`car_in` = `car_out` = 0) means no state change, and `err`/`fee_valid` are 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A request sampled at edge k produces its effect after edge k:
  - `occupied`, `free_count`, `full`, `fee`, `revenue` update;
  - `fee_valid` or `err` is high for exactly the cycle following edge k.
- Back-to-back requests on consecutive cycles are all processed. There are no stall states.
- An exit and a re-entry of the same slot on consecutive cycles are both accepted.
- `hour` changing in the same cycle as a request: the value sampled at that edge is used.
- Reset values (asserted asynchronously, held while `Start_n` = 0):
  - `occupied` = 0, all entry hours = 0;
  - `free_count` = N_SLOTS, `full` = 0;
  - `fee` = 0, `fee_valid` = 0, `err` = 0, `revenue` = 0.
- Reset mid-operation discards all occupancy and revenue immediately. The first request is accepted at the first rising edge after `Start_n` deasserts.

## Test plan
- Reset then idle: `Start_n` low 3 cycles → `occupied` = 0, `free_count` = 8, `full` = 0, `fee` = 0, `revenue` = 0, no pulses.
- Basic bill: `car_in` slot 2 at hour 5, `car_out` slot 2 at hour 9 → `fee_valid` 1 cycle, `fee` = 12, `revenue` = 12, `occupied[2]` = 0.
- Midnight wrap and minimum charge:
  - entry slot 0 at hour 22, exit at hour 3 → `fee` = 15;
  - entry slot 1 at hour 7, exit at hour 7 → `fee` = 3;
  - `revenue` = 18 after both exits.
- Errors, each producing one `err` pulse and no state change:
  - `car_in` to an occupied slot;
  - `car_out` from an empty slot;
  - `slot_id` = 9;
  - `car_in` and `car_out` together;
  - `hour` = 25.
- Fill and full: 8 entries to slots 0..7 on consecutive cycles → `free_count` = 0, `full` = 1; 9th `car_in` → `err`; one exit → `full` = 0, `free_count` = 1.
- Saturation and reset mid-run:
  - with RATE = 20, a 23-hour stay → `fee` = 255;
  - with REV_W = 8, repeated exits → `revenue` stops at 255;
  - asserting `Start_n` low between edges → all outputs return to reset values immediately.
